// File: rtl/display_pkg.sv
// Shared types and constants for the micro register interface.
package display_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYNC_W = DATA_W + 2;

  // Strobe handshake: one action per strobe, wait for strobe release.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Internal register map; everything at or above ADDR_EXT_BASE goes downstream.
  localparam logic [DATA_W-1:0] ADDR_BG_R     = 8'h00;
  localparam logic [DATA_W-1:0] ADDR_BG_G     = 8'h01;
  localparam logic [DATA_W-1:0] ADDR_BG_B     = 8'h02;
  localparam logic [DATA_W-1:0] ADDR_CTRL     = 8'h03;
  localparam logic [DATA_W-1:0] ADDR_EXT_BASE = 8'h04;

  // Power-on background colour and control.
  localparam logic [DATA_W-1:0] RST_BG_R = 8'h00;
  localparam logic [DATA_W-1:0] RST_BG_G = 8'h00;
  localparam logic [DATA_W-1:0] RST_BG_B = 8'h30;
  localparam logic [DATA_W-1:0] RST_CTRL = 8'h00;

  // True when the address targets the downstream write stream.
  function automatic logic is_ext_addr(input logic [DATA_W-1:0] addr);
    return addr >= ADDR_EXT_BASE;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank for asynchronous micro inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives a settled value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/micro_reg_if.sv
// Micro register interface: synchronized address/data strobes into local
// colour/control registers and a one-cycle write stream for downstream memories.
module micro_reg_if
  import display_pkg::*;
#(
  parameter int unsigned LED_STRETCH = 20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] fpga_port_in,
  input  logic       fpga_rsel,
  input  logic       fpga_write,
  output logic [7:0] bg_r,
  output logic [7:0] bg_g,
  output logic [7:0] bg_b,
  output logic [7:0] ctrl,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       led_1,
  output logic       led_2
);

  logic [SYNC_W-1:0]      sync_bus;
  logic [DATA_W-1:0]      s_data;
  logic                   s_rsel;
  logic                   s_write;

  state_t                 state;
  logic [DATA_W-1:0]      cap_data;
  logic                   cap_rsel;
  logic [DATA_W-1:0]      ptr;
  logic                   data_act;
  logic [LED_STRETCH-1:0] led_cnt;

  // All ten asynchronous micro bits share one synchronizer bank.
  sync_2ff #(
    .WIDTH (SYNC_W)
  ) u_sync (
    .clk   (Clk),
    .rst_n (Reset),
    .d     ({fpga_write, fpga_rsel, fpga_port_in}),
    .q     (sync_bus)
  );

  assign s_data  = sync_bus[DATA_W-1:0];
  assign s_rsel  = sync_bus[DATA_W];
  assign s_write = sync_bus[DATA_W+1];

  // A data action fires in the single CAPTURE cycle.
  assign data_act = (state == CAPTURE) && !cap_rsel;

  // Strobe FSM plus the register file and write stream it drives.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      cap_data <= '0;
      cap_rsel <= 1'b0;
      ptr      <= '0;
      bg_r     <= RST_BG_R;
      bg_g     <= RST_BG_G;
      bg_b     <= RST_BG_B;
      ctrl     <= RST_CTRL;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (s_write) begin
            cap_data <= s_data;
            cap_rsel <= s_rsel;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          state <= RELEASE;
          if (cap_rsel) begin
            ptr <= cap_data;
          end else begin
            if (is_ext_addr(ptr)) begin
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= cap_data;
            end else begin
              case (ptr)
                ADDR_BG_R: bg_r <= cap_data;
                ADDR_BG_G: bg_g <= cap_data;
                ADDR_BG_B: bg_b <= cap_data;
                ADDR_CTRL: ctrl <= cap_data;
                default:   ;
              endcase
            end
            // Natural 8-bit wrap takes 0xFF back to 0x00.
            ptr <= ptr + 8'd1;
          end
        end
        RELEASE: begin
          if (!s_write) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Activity stretch: reload on every data action, count down to zero.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      led_cnt <= '0;
      led_1   <= 1'b0;
    end else if (data_act) begin
      led_cnt <= '1;
      led_1   <= 1'b1;
    end else begin
      if (led_cnt != '0) begin
        led_cnt <= led_cnt - LED_STRETCH'(1);
      end
      // Tracks (next led_cnt != 0) so led_1 lines up with the counter.
      led_1 <= (led_cnt > LED_STRETCH'(1));
    end
  end

  assign led_2 = ctrl[0];

endmodule
